// File: rtl/partition_engine.sv
// partition_engine: table of disjoint region bitmasks with PNEW/PSPLIT/PMERGE/PDELETE under a valid/ready handshake
//   clk, rst_n               clock, asynchronous active-low reset
//   op, op_valid, op_ready   command handshake (accepted when op_valid & op_ready)
//   arg_region, arg_mask     PNEW region, PSPLIT mask
//   arg_m1, arg_m2           slot ids
//   done, err, err_code      one-cycle completion pulse with status
//   result_id, num_modules   last created/kept slot, count of valid slots
//   valid_mask, partitions   slot occupancy and flattened slot contents
//   mu_discovery/execution/cost  saturating mu counters
module partition_engine #(
  parameter int MAX_MODULES  = 8,
  parameter int REGION_WIDTH = 64,
  parameter int MU_WIDTH     = 32
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [7:0]                           op,
  input  logic                                 op_valid,
  output logic                                 op_ready,
  input  logic [REGION_WIDTH-1:0]              arg_region,
  input  logic [REGION_WIDTH-1:0]              arg_mask,
  input  logic [7:0]                           arg_m1,
  input  logic [7:0]                           arg_m2,
  output logic                                 done,
  output logic                                 err,
  output logic [2:0]                           err_code,
  output logic [7:0]                           result_id,
  output logic [7:0]                           num_modules,
  output logic [MAX_MODULES-1:0]               valid_mask,
  output logic [MAX_MODULES*REGION_WIDTH-1:0]  partitions,
  output logic [MU_WIDTH-1:0]                  mu_discovery,
  output logic [MU_WIDTH-1:0]                  mu_execution,
  output logic [MU_WIDTH-1:0]                  mu_cost
);
  localparam int IW = MAX_MODULES > 1 ? $clog2(MAX_MODULES) : 1;
  localparam logic [7:0] MAXM = 8'(MAX_MODULES);
  localparam logic [MU_WIDTH-1:0] MU_MAX = '1;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state;
  logic [7:0] l_op, l_m1, l_m2;
  logic [REGION_WIDTH-1:0] l_region, l_mask;
  logic [REGION_WIDTH-1:0] tbl [MAX_MODULES];
  logic [REGION_WIDTH-1:0] occ, r1, r2, sp;
  logic [IW-1:0] free_idx, i1, i2;
  logic bad1, bad2, has_free, ok;
  logic [2:0] ec;
  logic [31:0] pc_e;
  logic [MU_WIDTH-1:0] disc_n, exec_n;

  function automatic logic [31:0] pop(input logic [REGION_WIDTH-1:0] x);
    pop = '0;
    for (int i = 0; i < REGION_WIDTH; i++) pop += 32'(x[i]);
  endfunction

  // Widened add so popcounts larger than the counter range still saturate.
  function automatic logic [MU_WIDTH-1:0] sat(input logic [MU_WIDTH-1:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = 33'(a) + 33'(b);
    return s > 33'(MU_MAX) ? MU_MAX : s[MU_WIDTH-1:0];
  endfunction

  assign op_ready = (state == IDLE);

  for (genvar g = 0; g < MAX_MODULES; g++) begin : g_part
    assign partitions[g*REGION_WIDTH +: REGION_WIDTH] = tbl[g];
  end

  // Free slots are kept zeroed, so OR-ing every slot gives the occupied region set.
  always_comb begin
    occ = '0;
    free_idx = '0;
    for (int i = MAX_MODULES - 1; i >= 0; i--) begin
      occ |= tbl[i];
      if (!valid_mask[i]) free_idx = IW'(i);
    end
  end

  always_comb begin
    has_free = ~&valid_mask;
    i1 = l_m1[IW-1:0];
    i2 = l_m2[IW-1:0];
    bad1 = (l_m1 >= MAXM) || !valid_mask[i1];
    bad2 = (l_m2 >= MAXM) || !valid_mask[i2];
    r1 = tbl[i1];
    r2 = tbl[i2];
    sp = r1 & l_mask;
    ec = l_op == 8'h00 ? (l_region == '0 ? 3'd2 : |(l_region & occ) ? 3'd4 : !has_free ? 3'd3 : 3'd0)
       : l_op == 8'h01 ? (bad1 ? 3'd5 : (sp == '0 || sp == r1) ? 3'd6 : !has_free ? 3'd3 : 3'd0)
       : l_op == 8'h02 ? ((bad1 || bad2 || l_m1 == l_m2) ? 3'd5 : 3'd0)
       : l_op == 8'h03 ? (bad1 ? 3'd5 : 3'd0)
       : 3'd1;
    ok = (ec == 3'd0);
    pc_e = l_op == 8'h01 ? pop(r1) : l_op == 8'h02 ? pop(r1 | r2) : 32'd1;
    disc_n = (ok && l_op == 8'h00) ? sat(mu_discovery, pop(l_region)) : mu_discovery;
    exec_n = (ok && l_op != 8'h00) ? sat(mu_execution, pc_e) : mu_execution;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      l_op <= '0;
      l_m1 <= '0;
      l_m2 <= '0;
      l_region <= '0;
      l_mask <= '0;
      done <= 1'b0;
      err <= 1'b0;
      err_code <= '0;
      result_id <= '0;
      num_modules <= '0;
      valid_mask <= '0;
      mu_discovery <= '0;
      mu_execution <= '0;
      mu_cost <= '0;
      for (int i = 0; i < MAX_MODULES; i++) tbl[i] <= '0;
    end else begin
      case (state)
        IDLE: if (op_valid) begin
          l_op <= op;
          l_m1 <= arg_m1;
          l_m2 <= arg_m2;
          l_region <= arg_region;
          l_mask <= arg_mask;
          state <= EXEC;
        end
        EXEC: begin
          done <= 1'b1;
          err <= !ok;
          err_code <= ec;
          mu_discovery <= disc_n;
          mu_execution <= exec_n;
          mu_cost <= sat(disc_n, 32'(exec_n));
          if (ok) begin
            case (l_op)
              8'h00: begin
                tbl[free_idx] <= l_region;
                valid_mask[free_idx] <= 1'b1;
                result_id <= 8'(free_idx);
                num_modules <= num_modules + 8'd1;
              end
              8'h01: begin
                tbl[i1] <= r1 & ~l_mask;
                tbl[free_idx] <= sp;
                valid_mask[free_idx] <= 1'b1;
                result_id <= 8'(free_idx);
                num_modules <= num_modules + 8'd1;
              end
              8'h02: begin
                tbl[i1] <= r1 | r2;
                tbl[i2] <= '0;
                valid_mask[i2] <= 1'b0;
                result_id <= l_m1;
                num_modules <= num_modules - 8'd1;
              end
              default: begin
                tbl[i1] <= '0;
                valid_mask[i1] <= 1'b0;
                result_id <= l_m1;
                num_modules <= num_modules - 8'd1;
              end
            endcase
          end
          state <= RESP;
        end
        RESP: begin
          done <= 1'b0;
          err <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
